aexm_xmdu: RTL and testbench

- Parametrised iterative multiply/divide unit for the aexm execute stage.
- Successor to the single-cycle multiplier path, which is combinational and then registered.
- Adds high-word multiplies, signed and unsigned divide, a start/busy/done handshake, and divide-by-zero flagging.
- The execute stage issues an operation and holds the pipeline on busy. It takes result when done and x_en are both high.

---
 rtl/aexm_xmdu.sv | 141 ++++++++++++++
 tb/tb_aexm_xmdu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/aexm_xmdu.sv
// Iterative radix-2 multiply/divide unit for the aexm execute stage.
// Define AEXM_XMDU_FASTZERO_EN to let zero-operand multiplies and zero-dividend divides finish early.
`timescale 1ns/1ps
module aexm_xmdu #(
    parameter int DW    = 32,
    parameter int DIVEN = 1
) (
    input  logic          gclk,
    input  logic          grst,
    input  logic          x_en,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [DW-1:0] opa,
    input  logic [DW-1:0] opb,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          dbz
);

    localparam int CW = $clog2(DW);
    localparam bit HAS_DIV = (DIVEN != 0);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd3;
    localparam logic [2:0] OP_IDIV   = 3'd4;
    localparam logic [2:0] OP_IDIVU  = 3'd5;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} stateType;

    stateType        state, stateNext;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   opnd;
    logic [2:0]      opReg;
    logic            negReg;

    logic            isMul, isDiv, isRsv, isDbz, fastZero, early, accept;
    logic            aSigned, bSigned, aNeg, bNeg;
    logic [DW-1:0]   aMag, bMag;

    // Operand decode: signed ops iterate on magnitudes and fix the sign in FIX.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        isMul    = (op[2] == 1'b0);
        isDiv    = HAS_DIV && ((op == OP_IDIV) || (op == OP_IDIVU));
        isRsv    = !isMul && !isDiv;
        aSigned  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_IDIV);
        bSigned  = (op == OP_MULH) || (op == OP_IDIV);
        aNeg     = aSigned && opa[DW-1];
        bNeg     = bSigned && opb[DW-1];
        aMag     = aNeg ? -opa : opa;
        bMag     = bNeg ? -opb : opb;
        isDbz    = isDiv && (opa == '0);
`ifdef AEXM_XMDU_FASTZERO_EN
        fastZero = (isMul && ((opa == '0) || (opb == '0))) ||
                   (isDiv && (opb == '0) && (opa != '0));
`else
        fastZero = 1'b0;
`endif
        early    = isRsv || isDbz || fastZero;
    end

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: accept = start;
            ITER: if (cnt == '0) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: begin
                accept = x_en && start;
                if (x_en && !start) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (accept) stateNext = early ? DONE : ITER;
    end

    assign busy = (state == ITER) || (state == FIX);
    assign done = (state == DONE);

    logic [DW:0]     mulSum, divShift, divDiff;
    logic [2*DW-1:0] accStep, prodFix;
    logic [DW-1:0]   quotFix, fixVal;
    logic            regIsDiv;

    // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        regIsDiv = HAS_DIV && opReg[2];
        mulSum   = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
        divShift = {acc[2*DW-1:DW], acc[DW-1]};
        divDiff  = divShift - {1'b0, opnd};
        if (regIsDiv)
            accStep = divDiff[DW] ? {divShift[DW-1:0], acc[DW-2:0], 1'b0}
                                  : {divDiff[DW-1:0],  acc[DW-2:0], 1'b1};
        else
            accStep = {mulSum, acc[DW-1:1]};
        prodFix = negReg ? -acc : acc;
        quotFix = negReg ? -acc[DW-1:0] : acc[DW-1:0];
        if (regIsDiv)
            fixVal = quotFix;
        else if (opReg == OP_MUL)
            fixVal = prodFix[DW-1:0];
        else
            fixVal = prodFix[2*DW-1:DW];
    end

    always_ff @(posedge gclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (grst) state <= IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge gclk) begin
        if (grst) begin
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            opReg  <= '0;
            negReg <= 1'b0;
            result <= '0;
            dbz    <= 1'b0;
        end else if (accept) begin
            opReg  <= op;
            negReg <= aNeg ^ bNeg;
            opnd   <= aMag;
            acc    <= {{DW{1'b0}}, bMag};
            cnt    <= CW'(DW - 1);
            dbz    <= isDbz;
            if (early) result <= '0;
        end else if (state == ITER) begin
            acc <= accStep;
            if (cnt != '0) cnt <= cnt - CW'(1);
        end else if (state == FIX) begin
            result <= fixVal;
        end
    end

endmodule

// File: tb/tb_aexm_xmdu.sv
// Scoreboard bench for aexm_xmdu: stimulus pushes expectations, a negedge monitor pops them on consume.
`timescale 1ns/1ps
module tb_aexm_xmdu;

    localparam int DW = 32;
`ifdef AEXM_XMDU_FASTZERO_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = DW + 2;
`endif

    logic          gclk = 1'b0;
    logic          grst, x_en, start;
    logic [2:0]    op;
    logic [DW-1:0] opa, opb;
    logic          busy, done, dbz;
    logic [DW-1:0] result;

    typedef struct {
        logic [DW-1:0] res;
        logic          dbz;
        int            acc;
        int            lat;
        string         name;
    } expT;

    expT expQ[$];
    expT mon;
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  busyCnt;
    bit  seen;

    aexm_xmdu #(.DW(DW), .DIVEN(1)) dut (
        .gclk  (gclk),
        .grst  (grst),
        .x_en  (x_en),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .busy  (busy),
        .done  (done),
        .result(result),
        .dbz   (dbz)
    );

    always #5 gclk = ~gclk;
    always @(posedge gclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // The execute stage consumes a result when done and x_en are both high.
    always @(negedge gclk) begin
        if (!grst && done && x_en) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: result 0x%0h with no pending op", result);
            end else begin
                mon = expQ.pop_front();
                check({mon.name, " result"}, result, mon.res);
                check({mon.name, " dbz"}, dbz, mon.dbz);
                if (mon.lat != 0) check({mon.name, " latency"}, cyc - mon.acc + 1, mon.lat);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] er, input logic ed, input int lat, input string name);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        expQ.push_back('{er, ed, cyc + 1, lat, name});
        @(posedge gclk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        busyCnt = 0;
        seen    = 1'b0;
        for (int n = 0; n < DW + 20 && !seen; n++) begin
            @(negedge gclk);
            if (done) seen = 1'b1;
            else if (busy) busyCnt++;
        end
        check({name, " done seen"}, seen, 1);
        if (!seen) expQ.delete();
    endtask

    task automatic run(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] er, input logic ed, input int lat, input string name);
        issue(o, a, b, er, ed, lat, name);
        waitDone(name);
        @(posedge gclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        grst = 1'b1; x_en = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
        repeat (2) @(posedge gclk);
        @(negedge gclk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset dbz", dbz, 0);
        check("reset result", result, 0);
        @(posedge gclk);
        #1 grst = 1'b0;

        run(3'd0, 32'd7, 32'd6, 32'h0000002A, 1'b0, DW + 2, "mul 7x6");
        check("mul busy cycles", busyCnt, DW + 1);
        run(3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, DW + 2, "mulh -1x2");
        run(3'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, DW + 2, "mulhu");
        run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, DW + 2, "mulh minxmin");
        run(3'd3, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, DW + 2, "mulhsu neg a");
        run(3'd3, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 1'b0, DW + 2, "mulhsu big b");
        run(3'd0, 32'h00000010, 32'h12345678, 32'h23456780, 1'b0, DW + 2, "mul low wrap");
        run(3'd4, 32'h00000002, 32'hFFFFFFF9, 32'hFFFFFFFD, 1'b0, DW + 2, "idiv -7/2");
        run(3'd4, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 1'b0, DW + 2, "idiv overflow");
        run(3'd4, 32'hFFFFFFFE, 32'h00000007, 32'hFFFFFFFD, 1'b0, DW + 2, "idiv 7/-2");
        run(3'd4, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'h0000000E, 1'b0, DW + 2, "idiv -100/-7");
        run(3'd5, 32'h00000000, 32'd100, 32'h00000000, 1'b1, 1, "idivu by zero");
        run(3'd5, 32'h00000010, 32'hFFFFFFFF, 32'h0FFFFFFF, 1'b0, DW + 2, "idivu big");
        run(3'd5, 32'd7, 32'd5, 32'h00000000, 1'b0, DW + 2, "idivu small");
        run(3'd4, 32'h00000000, 32'd5, 32'h00000000, 1'b1, 1, "idiv by zero");
        run(3'd6, 32'd3, 32'd4, 32'h00000000, 1'b0, 1, "reserved 6");
        run(3'd7, 32'd3, 32'd4, 32'h00000000, 1'b0, 1, "reserved 7");
        run(3'd0, 32'd0, 32'd5, 32'h00000000, 1'b0, ZLAT, "mul zero");

        // Hold DONE with x_en low while a would-be divide-by-zero start is presented.
        x_en = 1'b0;
        issue(3'd0, 32'd1234, 32'd1000, 32'h0012D450, 1'b0, 0, "mul held");
        waitDone("mul held");
        for (int i = 0; i < 3; i++) begin
            @(posedge gclk);
            #1 start = 1'b1; op = 3'd5; opa = '0; opb = 32'd9;
            @(negedge gclk);
            check("hold result", result, 32'h0012D450);
            check("hold done", done, 1);
            check("hold dbz", dbz, 0);
        end
        @(posedge gclk);
        #1 x_en = 1'b1;
        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b0, DW + 2, "b2b mul 3x5");
        @(negedge gclk);
        check("b2b done low", done, 0);
        check("b2b busy", busy, 1);
        waitDone("b2b mul 3x5");
        @(posedge gclk);
        #1;

        // Abandon an operation with reset part-way through.
        issue(3'd0, 32'd7, 32'd6, 32'h0000002A, 1'b0, DW + 2, "mul abandoned");
        repeat (9) @(posedge gclk);
        @(negedge gclk);
        check("busy before reset", busy, 1);
        @(posedge gclk);
        #1 grst = 1'b1;
        expQ.delete();
        @(posedge gclk);
        @(negedge gclk);
        check("midop reset busy", busy, 0);
        check("midop reset done", done, 0);
        check("midop reset dbz", dbz, 0);
        check("midop reset result", result, 0);
        @(posedge gclk);
        #1 grst = 1'b0;
        run(3'd0, 32'd11, 32'd13, 32'd143, 1'b0, DW + 2, "mul after reset");

        repeat (3) @(posedge gclk);
        check("queue drained", expQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
